// File: rtl/pen_pkg.sv
// Shared types and helpers for the pending-request sequential encoder.
// Holds the FSM state encoding and a population-count function.
package pen_pkg;

    typedef enum logic {
        PEN_IDLE = 1'b0,
        PEN_HOLD = 1'b1
    } pen_state_e;

    // Widest request vector the popcount helper accepts.
    localparam int PEN_MAX_N = 64;

    function automatic int unsigned pen_popcount(input logic [PEN_MAX_N-1:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < PEN_MAX_N; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pen_seq_encoder_prio_find.sv
// Combinational descending search with wrap-around: start, start-1, ..., 0, N-1, ...
// Returns the first set position found and whether any bit was set.
module pen_prio_find #(
    parameter  int N    = 16,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [IDXW-1:0] start,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    function automatic int wrap_pos(input int s, input int i);
        int p;
        p = s - i;
        if (p < 0) begin
            p = p + N;
        end else begin
            p = p;
        end
        return p;
    endfunction

    // Scan from start downwards; the first hit is kept.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && vec[IDXW'(wrap_pos(int'(start), i))]) begin
                found = 1'b1;
                idx   = IDXW'(wrap_pos(int'(start), i));
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/pen_seq_encoder.sv
// Registered priority encoder with sticky pending requests and a valid/ready grant.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest index always wins.
module pen_seq_encoder
    import pen_pkg::*;
#(
    parameter  int N    = 16,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            any_o,
    output logic [IDXW:0]   pend_cnt_o
);

    pen_state_e      state_r;
    pen_state_e      state_nxt_s;
    logic [N-1:0]    pend_r;
    logic [N-1:0]    pend_nxt_s;
    logic [N-1:0]    clr_s;
    logic [N-1:0]    eligible_s;
    logic [IDXW-1:0] start_s;
    logic [IDXW-1:0] sel_idx_s;
    logic            found_s;
    logic [IDXW-1:0] idx_nxt_s;
    logic            valid_nxt_s;
    logic            accept_s;
    logic [IDXW:0]   cnt_nxt_s;
    logic [N-1:0]    one_s;

    assign one_s      = {{(N-1){1'b0}}, 1'b1};
    assign eligible_s = pend_r & ~mask_i;
    assign clr_s      = accept_s ? (one_s << idx_o) : {N{1'b0}};
    // Set beats clear when a request re-arrives on its own accept cycle.
    assign pend_nxt_s = (pend_r & ~clr_s) | req_i;
    assign cnt_nxt_s  = (IDXW+1)'(pen_popcount(PEN_MAX_N'(pend_nxt_s)));

`ifdef ROUND_ROBIN_EN
    logic [IDXW-1:0] rr_ptr_r;

    // Rotating pointer: next search begins just below the last accepted index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= IDXW'(N-1);
        end else if (accept_s) begin
            rr_ptr_r <= (idx_o == '0) ? IDXW'(N-1) : (idx_o - IDXW'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign start_s = rr_ptr_r;
`else
    assign start_s = IDXW'(N-1);
`endif

    pen_prio_find #(.N(N)) u_find (
        .vec   (eligible_s),
        .start (start_s),
        .idx   (sel_idx_s),
        .found (found_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PEN_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PEN_IDLE: begin
                if (found_s) state_nxt_s = PEN_HOLD;
                else         state_nxt_s = PEN_IDLE;
            end
            PEN_HOLD: begin
                if (ready_i) state_nxt_s = PEN_IDLE;
                else         state_nxt_s = PEN_HOLD;
            end
            default: state_nxt_s = PEN_IDLE;
        endcase
    end

    // FSM output logic; the held index never changes while a grant is offered.
    always_comb begin
        idx_nxt_s   = idx_o;
        valid_nxt_s = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            PEN_IDLE: begin
                if (found_s) begin
                    idx_nxt_s   = sel_idx_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    idx_nxt_s   = idx_o;
                    valid_nxt_s = 1'b0;
                end
            end
            PEN_HOLD: begin
                valid_nxt_s = ~ready_i;
                accept_s    = ready_i;
            end
            default: begin
                idx_nxt_s   = idx_o;
                valid_nxt_s = 1'b0;
                accept_s    = 1'b0;
            end
        endcase
    end

    // Pending vector and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= {N{1'b0}};
            idx_o      <= '0;
            valid_o    <= 1'b0;
            any_o      <= 1'b0;
            pend_cnt_o <= '0;
        end else begin
            pend_r     <= pend_nxt_s;
            idx_o      <= idx_nxt_s;
            valid_o    <= valid_nxt_s;
            any_o      <= |pend_nxt_s;
            pend_cnt_o <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_pen_seq_encoder.sv
// Directed self-checking bench for pen_seq_encoder (N=16); inputs change and
// outputs are sampled on the falling clock edge.
module tb_pen_seq_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_i;
    logic [15:0] mask_i;
    logic [3:0]  idx_o;
    logic        valid_o;
    logic        ready_i;
    logic        any_o;
    logic [4:0]  pend_cnt_o;

    int total;
    int bad;

    pen_seq_encoder #(.N(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .mask_i     (mask_i),
        .idx_o      (idx_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .any_o      (any_o),
        .pend_cnt_o (pend_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n  = 1'b0;
        req_i  = 16'h0000;
        mask_i = 16'h0000;
        ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({idx_o, valid_o, any_o, pend_cnt_o} !== 11'd0) begin bad++; $display("FAIL reset_init got idx=%0d v=%b any=%b cnt=%0d want all 0", idx_o, valid_o, any_o, pend_cnt_o); end
        req_i = 16'h0080;
        @(negedge clk); req_i = 16'h0000;
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd7) begin bad++; $display("FAIL reset_pre got v=%b idx=%0d want v=1 idx=7", valid_o, idx_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({idx_o, valid_o, any_o, pend_cnt_o} !== 11'd0) begin bad++; $display("FAIL reset_async got idx=%0d v=%b any=%b cnt=%0d want all 0", idx_o, valid_o, any_o, pend_cnt_o); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++; if (valid_o !== 1'b0 || any_o !== 1'b0 || pend_cnt_o !== 5'd0) begin bad++; $display("FAIL reset_after got v=%b any=%b cnt=%0d want 0 0 0", valid_o, any_o, pend_cnt_o); end
        end
    endtask

    task automatic test_single_walk();
        do_reset();
        ready_i = 1'b1;
        for (int j = 15; j >= 0; j--) begin
            req_i = 16'h0001 << j;
            @(negedge clk); req_i = 16'h0000;
            total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd1 || any_o !== 1'b1) begin bad++; $display("FAIL walk_pend j=%0d got v=%b cnt=%0d any=%b want 0 1 1", j, valid_o, pend_cnt_o, any_o); end
            @(negedge clk);
            total++; if (valid_o !== 1'b1 || idx_o !== 4'(j)) begin bad++; $display("FAIL walk_grant j=%0d got v=%b idx=%0d want 1 %0d", j, valid_o, idx_o, j); end
            @(negedge clk);
            total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd0 || any_o !== 1'b0) begin bad++; $display("FAIL walk_clear j=%0d got v=%b cnt=%0d any=%b want 0 0 0", j, valid_o, pend_cnt_o, any_o); end
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_idx [4];
        exp_idx[0] = 4'd15; exp_idx[1] = 4'd10; exp_idx[2] = 4'd5; exp_idx[3] = 4'd0;
        do_reset();
        ready_i = 1'b1;
        req_i = 16'h8421;
        @(negedge clk); req_i = 16'h0000;
        total++; if (pend_cnt_o !== 5'd4) begin bad++; $display("FAIL prio_cnt0 got %0d want 4", pend_cnt_o); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (valid_o !== 1'b1 || idx_o !== exp_idx[k] || pend_cnt_o !== 5'(4 - k)) begin bad++; $display("FAIL prio_grant k=%0d got v=%b idx=%0d cnt=%0d want 1 %0d %0d", k, valid_o, idx_o, pend_cnt_o, exp_idx[k], 4 - k); end
            @(negedge clk);
            total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'(3 - k)) begin bad++; $display("FAIL prio_acc k=%0d got v=%b cnt=%0d want 0 %0d", k, valid_o, pend_cnt_o, 3 - k); end
        end
        total++; if (any_o !== 1'b0) begin bad++; $display("FAIL prio_any got %b want 0", any_o); end
    endtask

    task automatic test_mask_backpressure();
        do_reset();
        req_i = 16'h0300; mask_i = 16'h0200;
        @(negedge clk); req_i = 16'h0000;
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd8 || pend_cnt_o !== 5'd2) begin bad++; $display("FAIL mask_grant got v=%b idx=%0d cnt=%0d want 1 8 2", valid_o, idx_o, pend_cnt_o); end
        for (int c = 0; c < 10; c++) begin
            req_i = (c == 2) ? 16'h8000 : 16'h0000;
            if (c == 5) mask_i = 16'h0300;
            if (c == 7) mask_i = 16'h0200;
            @(negedge clk);
            total++; if (valid_o !== 1'b1 || idx_o !== 4'd8) begin bad++; $display("FAIL mask_hold c=%0d got v=%b idx=%0d want 1 8", c, valid_o, idx_o); end
        end
        total++; if (pend_cnt_o !== 5'd3) begin bad++; $display("FAIL mask_cnt3 got %0d want 3", pend_cnt_o); end
        ready_i = 1'b1;
        @(negedge clk); ready_i = 1'b0;
        total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd2) begin bad++; $display("FAIL mask_acc8 got v=%b cnt=%0d want 0 2", valid_o, pend_cnt_o); end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd15) begin bad++; $display("FAIL mask_next got v=%b idx=%0d want 1 15", valid_o, idx_o); end
        ready_i = 1'b1;
        @(negedge clk); ready_i = 1'b0; mask_i = 16'h0000;
        total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd1 || any_o !== 1'b1) begin bad++; $display("FAIL mask_acc15 got v=%b cnt=%0d any=%b want 0 1 1", valid_o, pend_cnt_o, any_o); end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd9) begin bad++; $display("FAIL mask_unmask got v=%b idx=%0d want 1 9", valid_o, idx_o); end
        ready_i = 1'b1;
        @(negedge clk); ready_i = 1'b0;
        total++; if (pend_cnt_o !== 5'd0 || any_o !== 1'b0) begin bad++; $display("FAIL mask_drain got cnt=%0d any=%b want 0 0", pend_cnt_o, any_o); end
    endtask

    task automatic test_set_wins();
        do_reset();
        req_i = 16'h0100;
        @(negedge clk); req_i = 16'h0000;
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd8) begin bad++; $display("FAIL setw_grant got v=%b idx=%0d want 1 8", valid_o, idx_o); end
        ready_i = 1'b1; req_i = 16'h0100;
        @(negedge clk); req_i = 16'h0000;
        total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd1 || any_o !== 1'b1) begin bad++; $display("FAIL setw_keep got v=%b cnt=%0d any=%b want 0 1 1", valid_o, pend_cnt_o, any_o); end
        @(negedge clk);
        total++; if (valid_o !== 1'b1 || idx_o !== 4'd8) begin bad++; $display("FAIL setw_regrant got v=%b idx=%0d want 1 8", valid_o, idx_o); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0 || pend_cnt_o !== 5'd0) begin bad++; $display("FAIL setw_drain got v=%b cnt=%0d want 0 0", valid_o, pend_cnt_o); end
    endtask

    task automatic test_back_to_back();
        int exp_i;
        do_reset();
        ready_i = 1'b1; req_i = 16'hFFFF;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
`ifdef ROUND_ROBIN_EN
            exp_i = (15 - k + 16) % 16;
`else
            exp_i = 15;
`endif
            total++; if (valid_o !== 1'b1 || idx_o !== 4'(exp_i) || pend_cnt_o !== 5'd16) begin bad++; $display("FAIL b2b_grant k=%0d got v=%b idx=%0d cnt=%0d want 1 %0d 16", k, valid_o, idx_o, pend_cnt_o, exp_i); end
            @(negedge clk);
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_gap k=%0d got v=%b want 0", k, valid_o); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_walk();
        test_priority();
        test_mask_backpressure();
        test_set_wins();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
